systolic_array_ctrl: RTL and testbench

// Sequencer for the 4x4 systolic array multiplier. Accepts one job (A, B: 4x4 of 8-bit)
// via valid/ready, then clears the PE accumulators. It then streams skewed, zero-padded
// row/col data into the array with o_doProcess high, waits for the last PE to settle,

---
 rtl/systolic_array_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// ----------------------------------------------------------------------------
// systolic_array_ctrl
//
// Sequencer for a 4x4 output-stationary systolic array multiplier. It takes
// one job (matrices A and B) over a valid/ready handshake and pulses the
// array accumulator clear. It then streams skewed, zero-padded row and
// column data into the array while o_doProcess is high. After the last PE
// has settled it captures the 4x4 result and offers it on a second
// valid/ready handshake. Only one job is in flight at a time.
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_srst_n      synchronous active-low reset
//   i_valid       job request, i_a/i_b valid
//   o_ready       controller can accept a job (idle)
//   i_a, i_b      operand matrices, [row][col] of DATA_W bits
//   o_arrayClear  one-cycle accumulator clear pulse to the array
//   o_doProcess   array enable while streaming
//   o_row         row streams, element [i][0] is consumed by the array
//   o_col         column streams, element [j][0] is consumed by the array
//   i_c           raw accumulator values from the array
//   o_cValid      captured result valid
//   i_cReady      consumer accepts the result
//   o_c           captured result C = A*B (mod 2^ACC_W)
//   o_busy        controller is not idle
//   o_jobCount    completed-job counter, wraps
// ----------------------------------------------------------------------------
module systolic_array_ctrl #(
    parameter int N              = 4,
    parameter int DATA_W         = 8,
    parameter int ACC_W          = 16,
    parameter int COMPUTE_CYCLES = 10,
    parameter int DRAIN_CYCLES   = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_srst_n,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]        i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]        i_b,
    output logic                                   o_arrayClear,
    output logic                                   o_doProcess,
    output logic [N-1:0][2*N-2:0][DATA_W-1:0]      o_row,
    output logic [N-1:0][2*N-2:0][DATA_W-1:0]      o_col,
    input  logic [N-1:0][N-1:0][ACC_W-1:0]         i_c,
    output logic                                   o_cValid,
    input  logic                                   i_cReady,
    output logic [N-1:0][N-1:0][ACC_W-1:0]         o_c,
    output logic                                   o_busy,
    output logic [15:0]                            o_jobCount
);

    localparam int STREAM_LEN = 2 * N - 1;
    localparam int CNT_MAX    = (COMPUTE_CYCLES > DRAIN_CYCLES) ? COMPUTE_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               accept;
    logic               last_drain;
    logic               c_handshake;
    logic               next_ready;
    logic               next_clear;
    logic               next_process;
    logic               next_busy;

    // Next-state logic. The status outputs are decoded from the next state
    // here and registered below, so they change on the same edge as the
    // state itself and never glitch.
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        last_drain   = 1'b0;
        c_handshake  = 1'b0;
        next_ready   = 1'b0;
        next_clear   = 1'b0;
        next_process = 1'b0;
        next_busy    = 1'b1;

        case (state)
            ST_IDLE: begin
                if (i_valid && o_ready) begin
                    accept     = 1'b1;
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (cycle_cnt == CNT_W'(COMPUTE_CYCLES - 1)) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cycle_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    last_drain = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (o_cValid && i_cReady) begin
                    c_handshake = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        case (next_state)
            ST_IDLE: begin
                next_ready = 1'b1;
                next_busy  = 1'b0;
            end
            ST_CLEAR: begin
                next_clear = 1'b1;
            end
            ST_RUN: begin
                next_process = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State register together with the registered status outputs. Reset
    // drops any in-flight job and returns to idle with o_ready high.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state        <= ST_IDLE;
            o_ready      <= 1'b1;
            o_arrayClear <= 1'b0;
            o_doProcess  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= next_state;
            o_ready      <= next_ready;
            o_arrayClear <= next_clear;
            o_doProcess  <= next_process;
            o_busy       <= next_busy;
        end
    end

    // Shared cycle counter for RUN and DRAIN. It restarts at zero on every
    // state change, so each phase counts its own length from zero.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            cycle_cnt <= '0;
        end else if (next_state != state) begin
            cycle_cnt <= '0;
        end else if (state == ST_RUN || state == ST_DRAIN) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Operand streams. On accept, row i is loaded delayed by i slots and
    // column j delayed by j slots, with zero padding elsewhere. This makes
    // PE[i][j] see A[i][k] and B[k][j] in the same cycle. Each RUN edge
    // shifts toward slot 0 and back-fills with zero, so after STREAM_LEN
    // shifts the streams are empty and stay empty through DRAIN/DONE.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            o_row <= '0;
            o_col <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < STREAM_LEN; k++) begin
                    if (k >= i && k - i < N) begin
                        o_row[i][k] <= i_a[i][k-i];
                        o_col[i][k] <= i_b[k-i][i];
                    end else begin
                        o_row[i][k] <= '0;
                        o_col[i][k] <= '0;
                    end
                end
            end
        end else if (state == ST_RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < STREAM_LEN - 1; k++) begin
                    o_row[i][k] <= o_row[i][k+1];
                    o_col[i][k] <= o_col[i][k+1];
                end
                o_row[i][STREAM_LEN-1] <= '0;
                o_col[i][STREAM_LEN-1] <= '0;
            end
        end
    end

    // Result capture and job counting. The array output is sampled once at
    // the end of DRAIN and held unchanged until the consumer takes it.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            o_c        <= '0;
            o_cValid   <= 1'b0;
            o_jobCount <= '0;
        end else if (last_drain) begin
            o_c        <= i_c;
            o_cValid   <= 1'b1;
            o_jobCount <= o_jobCount + 16'd1;
        end else if (c_handshake) begin
            o_cValid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// ----------------------------------------------------------------------------
// tb_systolic_array_ctrl
//
// Directed bench for systolic_array_ctrl. A behavioural 4x4 output-stationary
// PE array is attached so that i_c carries real accumulator values. Expected
// results come from hand-written constants or from an independent
// matrix-multiply function.
// ----------------------------------------------------------------------------
module tb_systolic_array_ctrl;

    logic                       i_clk = 1'b0;
    logic                       i_srst_n;
    logic                       i_valid;
    logic                       o_ready;
    logic [3:0][3:0][7:0]       i_a;
    logic [3:0][3:0][7:0]       i_b;
    logic                       o_arrayClear;
    logic                       o_doProcess;
    logic [3:0][6:0][7:0]       o_row;
    logic [3:0][6:0][7:0]       o_col;
    logic [3:0][3:0][15:0]      i_c;
    logic                       o_cValid;
    logic                       i_cReady;
    logic [3:0][3:0][15:0]      o_c;
    logic                       o_busy;
    logic [15:0]                o_jobCount;

    int                         compare_count = 0;
    int                         fail_count    = 0;
    logic [15:0]                exp_jobs      = 16'd0;

    always #5 i_clk = ~i_clk;

    systolic_array_ctrl dut (
        .i_clk        (i_clk),
        .i_srst_n     (i_srst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_arrayClear (o_arrayClear),
        .o_doProcess  (o_doProcess),
        .o_row        (o_row),
        .o_col        (o_col),
        .i_c          (i_c),
        .o_cValid     (o_cValid),
        .i_cReady     (i_cReady),
        .o_c          (o_c),
        .o_busy       (o_busy),
        .o_jobCount   (o_jobCount)
    );

    logic [7:0]  pe_a_reg [4][4];
    logic [7:0]  pe_b_reg [4][4];
    logic [15:0] pe_acc   [4][4];
    logic [7:0]  pe_a_in  [4][4];
    logic [7:0]  pe_b_in  [4][4];

    // Operand routing inside the array model: A enters from the left and
    // moves right, B enters from the top and moves down.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pe_a_in[i][j] = 8'd0;
                pe_b_in[i][j] = 8'd0;
                if (j == 0) pe_a_in[i][j] = o_row[i][0];
                else        pe_a_in[i][j] = pe_a_reg[i][j-1];
                if (i == 0) pe_b_in[i][j] = o_col[j][0];
                else        pe_b_in[i][j] = pe_b_reg[i-1][j];
                i_c[i][j] = pe_acc[i][j];
            end
        end
    end

    // PE registers: the clear pulse empties the array, and the enable
    // advances operands and accumulates one product per PE.
    always @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (o_arrayClear) begin
                    pe_a_reg[i][j] <= 8'd0;
                    pe_b_reg[i][j] <= 8'd0;
                    pe_acc[i][j]   <= 16'd0;
                end else if (o_doProcess) begin
                    pe_a_reg[i][j] <= pe_a_in[i][j];
                    pe_b_reg[i][j] <= pe_b_in[i][j];
                    pe_acc[i][j]   <= pe_acc[i][j] + 16'(pe_a_in[i][j]) * 16'(pe_b_in[i][j]);
                end
            end
        end
    end

    // Global safety net in case a bounded loop is ever bypassed.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0][3:0][15:0] matmul(input logic [3:0][3:0][7:0] a,
                                                     input logic [3:0][3:0][7:0] b);
        logic [3:0][3:0][15:0] r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[i][j] = 16'd0;
                for (int k = 0; k < 4; k++) begin
                    r[i][j] = r[i][j] + 16'(a[i][k]) * 16'(b[k][j]);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0][3:0][7:0] randMatrix();
        logic [3:0][3:0][7:0] m;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                m[i][j] = 8'($urandom_range(0, 255));
            end
        end
        return m;
    endfunction

    task automatic waitCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0][3:0][7:0] a,
                                 input logic [3:0][3:0][7:0] b);
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitResult(input string tag);
        int cycles;
        cycles = 0;
        while (!o_cValid && cycles < 50) begin
            waitCycle();
            cycles++;
        end
        checkOutput({tag, "_latency"}, 256'(cycles), 256'(12));
    endtask

    task automatic doJob(input logic [3:0][3:0][7:0] a, input logic [3:0][3:0][7:0] b,
                         input logic [3:0][3:0][15:0] exp_c, input string tag);
        int cycles;
        applyStimulus(a, b);
        cycles = 0;
        while (!o_ready && cycles < 50) begin
            waitCycle();
            cycles++;
        end
        waitCycle();
        i_valid = 1'b0;
        checkOutput({tag, "_accepted_busy"}, 256'(o_busy), 256'(1));
        waitResult(tag);
        checkOutput({tag, "_result"}, 256'(o_c), 256'(exp_c));
        exp_jobs = exp_jobs + 16'd1;
        checkOutput({tag, "_jobcount"}, 256'(o_jobCount), 256'(exp_jobs));
        i_cReady = 1'b1;
        waitCycle();
        i_cReady = 1'b0;
        checkOutput({tag, "_cvalid_drop"}, 256'(o_cValid), 256'(0));
        checkOutput({tag, "_ready_back"}, 256'(o_ready), 256'(1));
    endtask

    initial begin
        logic [3:0][3:0][7:0]  ma;
        logic [3:0][3:0][7:0]  mb;
        logic [3:0][3:0][15:0] mc;
        logic [3:0][6:0][7:0]  exp_row;
        logic [3:0][6:0][7:0]  exp_col;
        logic [3:0][7:0]       obs_r;
        logic [3:0][7:0]       exp_r;
        logic [3:0][7:0]       obs_k;
        logic [3:0][7:0]       exp_k;
        int                    clr_cnt;
        int                    clr_idx;
        int                    dp_cnt;
        int                    dp_first;

        i_srst_n = 1'b0;
        i_valid  = 1'b0;
        i_cReady = 1'b0;
        i_a      = '0;
        i_b      = '0;

        $display("[TB] T1 reset");
        waitCycle();
        waitCycle();
        checkOutput("t1_ready", 256'(o_ready), 256'(1));
        checkOutput("t1_busy", 256'(o_busy), 256'(0));
        checkOutput("t1_cvalid", 256'(o_cValid), 256'(0));
        checkOutput("t1_jobcount", 256'(o_jobCount), 256'(0));
        checkOutput("t1_row", 256'(o_row), 256'(0));
        checkOutput("t1_col", 256'(o_col), 256'(0));
        checkOutput("t1_clear", 256'(o_arrayClear), 256'(0));
        checkOutput("t1_process", 256'(o_doProcess), 256'(0));
        checkOutput("t1_c", 256'(o_c), 256'(0));
        i_srst_n = 1'b1;
        i_cReady = 1'b1;
        waitCycle();
        i_cReady = 1'b0;
        checkOutput("t1_stray_cready_ready", 256'(o_ready), 256'(1));
        checkOutput("t1_stray_cready_cvalid", 256'(o_cValid), 256'(0));

        $display("[TB] T2 identity");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (r == c) ? 8'd1 : 8'd0;
                mb[r][c] = 8'(4 * r + c + 1);
                mc[r][c] = 16'(4 * r + c + 1);
            end
        end
        doJob(ma, mb, mc, "t2");

        $display("[TB] T3 stream check");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 8'(16 * r + c);
                mb[r][c] = 8'(r + 2 * c + 3);
            end
        end
        exp_row = '0;
        exp_col = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                exp_row[i][k+i] = ma[i][k];
                exp_col[i][k+i] = mb[k][i];
            end
        end
        applyStimulus(ma, mb);
        waitCycle();
        i_valid = 1'b0;
        checkOutput("t3_row_load", 256'(o_row), 256'(exp_row));
        checkOutput("t3_col_load", 256'(o_col), 256'(exp_col));
        clr_cnt  = 0;
        clr_idx  = -1;
        dp_cnt   = 0;
        dp_first = -1;
        for (int s = 0; s < 12; s++) begin
            if (o_arrayClear) begin
                clr_cnt++;
                clr_idx = s;
            end
            if (o_doProcess) begin
                if (dp_first < 0) dp_first = s;
                for (int i = 0; i < 4; i++) begin
                    obs_r[i] = o_row[i][0];
                    obs_k[i] = o_col[i][0];
                    exp_r[i] = 8'd0;
                    exp_k[i] = 8'd0;
                    if (dp_cnt - i >= 0 && dp_cnt - i < 4) begin
                        exp_r[i] = ma[i][dp_cnt-i];
                        exp_k[i] = mb[dp_cnt-i][i];
                    end
                end
                checkOutput($sformatf("t3_row0_t%0d", dp_cnt), 256'(obs_r), 256'(exp_r));
                checkOutput($sformatf("t3_col0_t%0d", dp_cnt), 256'(obs_k), 256'(exp_k));
                dp_cnt++;
            end
            waitCycle();
        end
        checkOutput("t3_clear_count", 256'(clr_cnt), 256'(1));
        checkOutput("t3_clear_index", 256'(clr_idx), 256'(0));
        checkOutput("t3_process_first", 256'(dp_first), 256'(1));
        checkOutput("t3_process_count", 256'(dp_cnt), 256'(10));
        checkOutput("t3_cvalid", 256'(o_cValid), 256'(1));
        checkOutput("t3_result", 256'(o_c), 256'(matmul(ma, mb)));
        exp_jobs = exp_jobs + 16'd1;
        checkOutput("t3_jobcount", 256'(o_jobCount), 256'(exp_jobs));

        $display("[TB] T4 back-pressure");
        mc = matmul(ma, mb);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 8'hFF;
                mb[r][c] = 8'hFF;
            end
        end
        applyStimulus(ma, mb);
        for (int s = 0; s < 20; s++) begin
            waitCycle();
            checkOutput($sformatf("t4_hold_c_%0d", s), 256'(o_c), 256'(mc));
            checkOutput($sformatf("t4_hold_ready_%0d", s), 256'(o_ready), 256'(0));
            checkOutput($sformatf("t4_hold_cvalid_%0d", s), 256'(o_cValid), 256'(1));
        end
        i_cReady = 1'b1;
        waitCycle();
        i_cReady = 1'b0;
        checkOutput("t4_release_cvalid", 256'(o_cValid), 256'(0));
        checkOutput("t4_release_ready", 256'(o_ready), 256'(1));
        checkOutput("t4_release_busy", 256'(o_busy), 256'(0));
        waitCycle();
        i_valid = 1'b0;
        checkOutput("t4_accept_ready", 256'(o_ready), 256'(0));
        checkOutput("t4_accept_clear", 256'(o_arrayClear), 256'(1));

        $display("[TB] T5 wrap and back-to-back");
        waitResult("t5_ff");
        checkOutput("t5_ff_result", 256'(o_c), {16{16'hF804}});
        exp_jobs = exp_jobs + 16'd1;
        checkOutput("t5_ff_jobcount", 256'(o_jobCount), 256'(exp_jobs));
        i_cReady = 1'b1;
        waitCycle();
        i_cReady = 1'b0;
        ma = randMatrix();
        mb = randMatrix();
        doJob(ma, mb, matmul(ma, mb), "t5_job2");
        ma = randMatrix();
        mb = randMatrix();
        doJob(ma, mb, matmul(ma, mb), "t5_job3");

        $display("[TB] T6 reset mid-job");
        ma = randMatrix();
        mb = randMatrix();
        applyStimulus(ma, mb);
        waitCycle();
        i_valid = 1'b0;
        for (int s = 0; s < 5; s++) waitCycle();
        checkOutput("t6_in_run", 256'(o_doProcess), 256'(1));
        i_srst_n = 1'b0;
        waitCycle();
        i_srst_n = 1'b1;
        checkOutput("t6_ready", 256'(o_ready), 256'(1));
        checkOutput("t6_busy", 256'(o_busy), 256'(0));
        checkOutput("t6_process", 256'(o_doProcess), 256'(0));
        checkOutput("t6_clear", 256'(o_arrayClear), 256'(0));
        checkOutput("t6_cvalid", 256'(o_cValid), 256'(0));
        checkOutput("t6_jobcount", 256'(o_jobCount), 256'(0));
        checkOutput("t6_row", 256'(o_row), 256'(0));
        checkOutput("t6_col", 256'(o_col), 256'(0));
        checkOutput("t6_c", 256'(o_c), 256'(0));
        exp_jobs = 16'd0;
        ma = randMatrix();
        mb = randMatrix();
        doJob(ma, mb, matmul(ma, mb), "t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
